sipo_word_capture: RTL

//  Serial-in/parallel-out capture stage. It samples a 1-bit serial stream
//  (D, qualified by EN) into a WIDTH-bit shift register and counts bits.
//  It transfers each completed word into a holding register, offered

---
 rtl/sipo_word_capture_pkg.sv | 17 +
 rtl/sipo_word_capture_if.sv | 27 ++
 rtl/sipo_bit_counter.sv | 39 +++
 rtl/sipo_word_capture.sv | 121 ++++++++++++
 4 files changed

// File: rtl/sipo_word_capture_pkg.sv
// Shared definitions for the serial capture stages: bit-order selector
// and the two-state holding-register encoding.
package sipo_word_capture_pkg;

    // Which end of the word the first received bit lands in.
    typedef enum logic {
        BIT_ORDER_LSB = 1'b0,
        BIT_ORDER_MSB = 1'b1
    } bit_order_e;

    // Holding register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } cap_state_e;

endpackage : sipo_word_capture_pkg

// File: rtl/sipo_word_capture_if.sv
// Serial input strobe plus the VALID/READY word output of the capture stage.
// master = the side feeding bits and consuming words, slave = the capture stage.
interface sipo_word_capture_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             d;
    logic             en;
    logic             ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             overrun;
    logic [CW-1:0]    bitcnt;

    modport master (
        output d, en, ready, clr_ovr,
        input  q, valid, overrun, bitcnt
    );

    modport slave (
        input  d, en, ready, clr_ovr,
        output q, valid, overrun, bitcnt
    );

endinterface : sipo_word_capture_if

// File: rtl/sipo_bit_counter.sv
// Bit position counter for one serial word. Wraps explicitly at WIDTH-1
// so non-power-of-two widths behave; wrap is high in the cycle whose
// strobe carries the last bit of the word.
module sipo_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] bitcnt,
    output logic                     wrap
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    assign wrap   = en & (cnt_r == LAST);
    assign bitcnt = cnt_r;

    // Count strobes, wrapping to zero on the last bit of a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= ZERO;
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= ZERO;
            end else begin
                cnt_r <= cnt_r + ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule : sipo_bit_counter

// File: rtl/sipo_word_capture.sv
// Serial-in/parallel-out capture: shifts EN-qualified bits into a word,
// hands each completed word to a holding register with VALID/READY, and
// flags a sticky OVERRUN when a completed word finds the register still
// occupied and not being drained.
module sipo_word_capture
    import sipo_word_capture_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_word_capture_if.slave   bus
);

    localparam logic [WIDTH-1:0] WZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] sh_r;
    logic [WIDTH-1:0] sh_next_s;
    logic [WIDTH-1:0] q_r;
    logic             valid_r;
    logic             overrun_r;
    cap_state_e       state_r;
    logic             complete_s;
    logic             drop_s;
    logic [$clog2(WIDTH)-1:0] bitcnt_s;

    sipo_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en),
        .bitcnt (bitcnt_s),
        .wrap   (complete_s)
    );

    // Next shift-register value including the bit sampled this cycle.
    always_comb begin
        sh_next_s = sh_r;
        if (MSB_FIRST == BIT_ORDER_MSB) begin
            sh_next_s = {sh_r[WIDTH-2:0], bus.d};
        end else begin
            sh_next_s = {bus.d, sh_r[WIDTH-1:1]};
        end
    end

    // A completed word is lost when the holder is full and not draining.
    always_comb begin
        drop_s = 1'b0;
        if (complete_s && (state_r == ST_FULL) && !bus.ready) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // Shift register: advances only on a bit strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_r <= WZERO;
        end else if (bus.en) begin
            sh_r <= sh_next_s;
        end else begin
            sh_r <= sh_r;
        end
    end

    // Holding-register FSM: loads completed words, drains on READY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            q_r     <= WZERO;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (complete_s) begin
                        state_r <= ST_FULL;
                        valid_r <= 1'b1;
                        q_r     <= sh_next_s;
                    end
                end
                ST_FULL: begin
                    if (complete_s) begin
                        // Reload only when the current word leaves this cycle.
                        if (bus.ready) begin
                            q_r <= sh_next_s;
                        end
                    end else if (bus.ready) begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun flag: a drop outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.q       = q_r;
    assign bus.valid   = valid_r;
    assign bus.overrun = overrun_r;
    assign bus.bitcnt  = bitcnt_s;

endmodule : sipo_word_capture
